// File: rtl/kbd_tx_queue_if.sv
// Handshake bundle between the keyboard ASCII path, the transmit queue and the UART.
// master = surrounding system (keyboard source plus UART), slave = the queue itself.
interface kbd_tx_queue_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          in_byte;
  logic                in_valid;
  logic                tx_busy;
  logic [7:0]          tx_byte;
  logic                transmit;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport master (
    output in_byte, in_valid, tx_busy,
    input  tx_byte, transmit, full, empty, count, overflow
  );

  modport slave (
    input  in_byte, in_valid, tx_busy,
    output tx_byte, transmit, full, empty, count, overflow
  );
endinterface

// File: rtl/kbd_tx_queue.sv
// kbd_tx_queue: FIFO between keyboard ASCII strobes and the UART, drained one byte per busy period.
// Optional macro KBD_TX_CRLF_EXPAND_EN: every CR taken from the FIFO is followed by an LF on the wire.
module kbd_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic           clk,
  input logic           rst,
  kbd_tx_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  push;
  logic                  pop;
  logic [7:0]            head;
`ifdef KBD_TX_CRLF_EXPAND_EN
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  logic                  lf_pending_q, lf_pending_d;
`endif

  assign head = mem_q[rd_ptr_q];
  // A pop only happens as the drain FSM loads from IDLE; a full FIFO still accepts a byte that cycle.
  assign pop  = (state_q == IDLE) && !empty_q && !bus.tx_busy;
  assign push = bus.in_valid && (!full_q || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.in_valid & full_q & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
`ifdef KBD_TX_CRLF_EXPAND_EN
    lf_pending_d = lf_pending_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_byte_d = head;
          state_d   = SEND;
`ifdef KBD_TX_CRLF_EXPAND_EN
          lf_pending_d = (head == CR);
`endif
        end
      end
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_IDLE;
      WAIT_IDLE: begin
        if (!bus.tx_busy) begin
`ifdef KBD_TX_CRLF_EXPAND_EN
          // The LF goes straight back to SEND without consuming a FIFO entry.
          if (lf_pending_q) begin
            tx_byte_d    = LF;
            lf_pending_d = 1'b0;
            state_d      = SEND;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.in_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_byte_q  <= 8'h00;
`ifdef KBD_TX_CRLF_EXPAND_EN
      lf_pending_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_byte_q  <= tx_byte_d;
`ifdef KBD_TX_CRLF_EXPAND_EN
      lf_pending_q <= lf_pending_d;
`endif
    end
  end

  assign bus.tx_byte  = tx_byte_q;
  assign bus.transmit = (state_q == SEND);
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_kbd_tx_queue.sv
// Bench for kbd_tx_queue: a 16-deep instance (a) and a 4-deep instance (b), each with a UART busy model
// and a scoreboard of bytes expected on the wire, compared whenever transmit pulses.
module tb_kbd_tx_queue;
  localparam int BUSY_LEN = 20;

  typedef struct {
    bit         in_valid;
    logic [7:0] in_byte;
    bit         busy;
    bit         accept;
    int         exp_count;
    bit         exp_full;
    bit         exp_empty;
    bit         exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  kbd_tx_queue_if #(.DEPTH_LOG2(4)) bus_a ();
  kbd_tx_queue_if #(.DEPTH_LOG2(2)) bus_b ();

  kbd_tx_queue #(.DEPTH_LOG2(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  kbd_tx_queue #(.DEPTH_LOG2(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;

  bit         force_busy_a = 1'b0;
  bit         force_busy_b = 1'b0;
  int         busy_cnt_a = 0;
  int         busy_cnt_b = 0;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic       prev_tx_a = 1'b0;
  logic       prev_tx_b = 1'b0;

  // UART model: busy for BUSY_LEN cycles after each start pulse, unaffected by the queue's reset.
  always @(posedge clk) begin
    if (bus_a.transmit) busy_cnt_a <= BUSY_LEN;
    else if (busy_cnt_a != 0) busy_cnt_a <= busy_cnt_a - 1;
    if (bus_b.transmit) busy_cnt_b <= BUSY_LEN;
    else if (busy_cnt_b != 0) busy_cnt_b <= busy_cnt_b - 1;
  end

  assign bus_a.tx_busy = force_busy_a || (busy_cnt_a != 0);
  assign bus_b.tx_busy = force_busy_b || (busy_cnt_b != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int sel, input logic [7:0] b);
    if (sel == 0) exp_q_a.push_back(b);
    else          exp_q_b.push_back(b);
`ifdef KBD_TX_CRLF_EXPAND_EN
    if (b == 8'h0D) begin
      if (sel == 0) exp_q_a.push_back(8'h0A);
      else          exp_q_b.push_back(8'h0A);
    end
`endif
  endtask

  always @(negedge clk) begin
    if (bus_a.transmit) begin
      chk("a_tx_while_busy", bus_a.tx_busy, 1'b0);
      chk("a_tx_back_to_back", prev_tx_a, 1'b0);
      if (exp_q_a.size() == 0) chk("a_unexpected_tx", bus_a.tx_byte, 32'hFFFF_FFFF);
      else                     chk("a_tx_byte", bus_a.tx_byte, exp_q_a.pop_front());
    end
    prev_tx_a = bus_a.transmit;
    if (bus_b.transmit) begin
      chk("b_tx_while_busy", bus_b.tx_busy, 1'b0);
      chk("b_tx_back_to_back", prev_tx_b, 1'b0);
      if (exp_q_b.size() == 0) chk("b_unexpected_tx", bus_b.tx_byte, 32'hFFFF_FFFF);
      else                     chk("b_tx_byte", bus_b.tx_byte, exp_q_b.pop_front());
    end
    prev_tx_b = bus_b.transmit;
  end

  task automatic check_output(input int sel, input vec_t v);
    if (sel == 0) begin
      chk("a_count", 32'(bus_a.count), v.exp_count);
      chk("a_full", bus_a.full, v.exp_full);
      chk("a_empty", bus_a.empty, v.exp_empty);
      chk("a_overflow", bus_a.overflow, v.exp_ovf);
    end else begin
      chk("b_count", 32'(bus_b.count), v.exp_count);
      chk("b_full", bus_b.full, v.exp_full);
      chk("b_empty", bus_b.empty, v.exp_empty);
      chk("b_overflow", bus_b.overflow, v.exp_ovf);
    end
  endtask

  // Drives one vector for one clock, then checks the registered state it produced.
  task automatic apply_stimulus(input int sel, input vec_t v);
    if (sel == 0) begin
      bus_a.in_valid = v.in_valid; bus_a.in_byte = v.in_byte; force_busy_a = v.busy;
    end else begin
      bus_b.in_valid = v.in_valid; bus_b.in_byte = v.in_byte; force_busy_b = v.busy;
    end
    if (v.in_valid && v.accept) sb_push(sel, v.in_byte);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    check_output(sel, v);
  endtask

  task automatic push_byte(input int sel, input logic [7:0] b);
    if (sel == 0) begin bus_a.in_valid = 1'b1; bus_a.in_byte = b; end
    else          begin bus_b.in_valid = 1'b1; bus_b.in_byte = b; end
    sb_push(sel, b);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int sel);
    int n = 0;
    while (((sel == 0) ? exp_q_a.size() : exp_q_b.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk((sel == 0) ? "a_drain_timeout" : "b_drain_timeout", 32'(n >= 3000), 0);
    repeat (BUSY_LEN + 6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t burst[6];
  vec_t ovf[7];

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_byte = 8'h00;
    bus_b.in_valid = 1'b0; bus_b.in_byte = 8'h00;

    for (int i = 0; i < 5; i++)
      burst[i] = '{1'b1, 8'(8'h31 + i), 1'b1, 1'b1, i + 1, 1'b0, 1'b0, 1'b0};
    burst[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 6; i++)
      ovf[i] = '{1'b1, 8'(8'hA0 + i), 1'b1, (i < 4), (i < 4) ? i + 1 : 4, (i >= 3), 1'b0, (i >= 4)};
    ovf[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx_byte", bus_a.tx_byte, 8'h00);
    chk("rst_transmit", bus_a.transmit, 1'b0);
    chk("rst_full", bus_a.full, 1'b0);
    chk("rst_empty", bus_a.empty, 1'b1);
    chk("rst_count", 32'(bus_a.count), 0);
    chk("rst_overflow", bus_a.overflow, 1'b0);

    $display("[TB] single byte latency");
    bus_a.in_valid = 1'b1; bus_a.in_byte = 8'h41;
    sb_push(0, 8'h41);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    chk("lat_n1_transmit", bus_a.transmit, 1'b0);
    chk("lat_n1_count", 32'(bus_a.count), 1);
    @(posedge clk); #1;
    chk("lat_n2_transmit", bus_a.transmit, 1'b1);
    chk("lat_n2_tx_byte", bus_a.tx_byte, 8'h41);
    @(posedge clk); #1;
    chk("lat_n3_transmit", bus_a.transmit, 1'b0);
    wait_drain(0);
    chk("lat_empty_after", bus_a.empty, 1'b1);
    chk("lat_count_after", 32'(bus_a.count), 0);

    $display("[TB] burst while busy");
    foreach (burst[i]) apply_stimulus(0, burst[i]);
    force_busy_a = 1'b0;
    wait_drain(0);
    chk("burst_empty_after", bus_a.empty, 1'b1);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) push_byte(0, 8'(8'hD0 + i));
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_count_before", 32'(bus_a.count), 3);
    exp_q_a.delete();
    do_reset();
    chk("midrst_tx_byte", bus_a.tx_byte, 8'h00);
    chk("midrst_transmit", bus_a.transmit, 1'b0);
    chk("midrst_full", bus_a.full, 1'b0);
    chk("midrst_empty", bus_a.empty, 1'b1);
    chk("midrst_count", 32'(bus_a.count), 0);
    chk("midrst_overflow", bus_a.overflow, 1'b0);
    push_byte(0, 8'hE0);
    wait_drain(0);

    $display("[TB] CR handling");
    push_byte(0, 8'h0D);
    push_byte(0, 8'h61);
    wait_drain(0);
    chk("cr_empty_after", bus_a.empty, 1'b1);

    $display("[TB] depth 4 overflow");
    do_reset();
    foreach (ovf[i]) apply_stimulus(1, ovf[i]);
    force_busy_b = 1'b0;
    wait_drain(1);
    chk("ovf_sticky", bus_b.overflow, 1'b1);
    chk("ovf_count_after", 32'(bus_b.count), 0);

    $display("[TB] push and pop while full");
    do_reset();
    force_busy_b = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(1, 8'(8'hC0 + i));
    chk("pp_full_before", bus_b.full, 1'b1);
    force_busy_b = 1'b0;
    push_byte(1, 8'hC4);
    chk("pp_count", 32'(bus_b.count), 4);
    chk("pp_full", bus_b.full, 1'b1);
    chk("pp_overflow", bus_b.overflow, 1'b0);
    wait_drain(1);
    chk("pp_empty_after", bus_b.empty, 1'b1);
    chk("pp_overflow_after", bus_b.overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
